// File: rtl/seg_disp_pkg.sv
// Shared constants, types and helpers for the 4-digit 7-segment scan logic.
package seg_disp_pkg;

    localparam int               NUM_DIGITS = 4;
    localparam logic [3:0]       AN_OFF     = 4'b1111;
    localparam logic             DP_OFF     = 1'b1;

    typedef logic [1:0] digit_idx_t;

    // Active-low anode pattern with only the selected digit pulled low.
    function automatic logic [NUM_DIGITS-1:0] onehot_an(input digit_idx_t idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot timer: counts cycles within a digit slot and steps the digit index.
// Exposes next-state digit/blank so the caller can register glitch-free outputs.
module seg_slot_timer
    import seg_disp_pkg::*;
#(
    parameter int DIGIT_TICKS = 100000,
    parameter int BLANK_TICKS = 2000,
    parameter int CNT_W       = $clog2(DIGIT_TICKS)
) (
    input  logic       clk,
    input  logic       rst_n,
    output digit_idx_t digit_next,
    output logic       blank_next,
    output logic       frame_edge
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    digit_idx_t       digit;
    logic             wrap;

    // Next-state of the slot counter and digit index, plus edge strobes.
    always_comb begin
        wrap       = (cnt == CNT_W'(DIGIT_TICKS - 1));
        frame_edge = wrap && (digit == digit_idx_t'(NUM_DIGITS - 1));
        cnt_next   = wrap ? '0 : cnt + 1'b1;
        digit_next = wrap ? digit + 1'b1 : digit;
        blank_next = (cnt_next < CNT_W'(BLANK_TICKS));
    end

    // Slot counter and digit index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            digit <= '0;
        end else begin
            cnt   <= cnt_next;
            digit <= digit_next;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode display.
// Loaded values are held in a pending buffer and promoted to the active
// buffer only at frame boundaries, so a frame never mixes old and new data.
module seg_scan_ctrl
    import seg_disp_pkg::*;
#(
    parameter int DIGIT_TICKS = 100000,
    parameter int BLANK_TICKS = 2000,
    parameter int CNT_W       = $clog2(DIGIT_TICKS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  den_in,
    output logic [3:0]  nibble,
    output logic        nib_en,
    output logic [3:0]  an,
    output logic        dp,
    output logic        pend_valid,
    output logic        frame_tick
);

    digit_idx_t  digit_next;
    logic        blank_next;
    logic        frame_edge;

    logic [15:0] pend_value;
    logic [3:0]  pend_dp;
    logic [3:0]  pend_den;
    logic [15:0] act_value, act_value_next;
    logic [3:0]  act_dp,    act_dp_next;
    logic [3:0]  act_den,   act_den_next;

    logic [3:0]  nibble_next;
    logic        nib_en_next;
    logic [3:0]  an_next;
    logic        dp_next;

    seg_slot_timer #(
        .DIGIT_TICKS (DIGIT_TICKS),
        .BLANK_TICKS (BLANK_TICKS),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit_next (digit_next),
        .blank_next (blank_next),
        .frame_edge (frame_edge)
    );

    // Active buffer next-state: a load on the frame edge bypasses pending.
    always_comb begin
        act_value_next = act_value;
        act_dp_next    = act_dp;
        act_den_next   = act_den;
        if (frame_edge) begin
            if (load) begin
                act_value_next = value_in;
                act_dp_next    = dp_in;
                act_den_next   = den_in;
            end else if (pend_valid) begin
                act_value_next = pend_value;
                act_dp_next    = pend_dp;
                act_den_next   = pend_den;
            end
        end
    end

    // Output next-state, derived from the upcoming digit and active data.
    always_comb begin
        nibble_next = act_value_next[{digit_next, 2'b00} +: 4];
        nib_en_next = 1'b0;
        an_next     = AN_OFF;
        dp_next     = DP_OFF;
        if (!blank_next && act_den_next[digit_next]) begin
            nib_en_next = 1'b1;
            an_next     = onehot_an(digit_next);
            dp_next     = ~act_dp_next[digit_next];
        end
    end

    // Pending buffer: last load before a frame edge wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_den   <= '0;
            pend_valid <= 1'b0;
        end else if (load && !frame_edge) begin
            pend_value <= value_in;
            pend_dp    <= dp_in;
            pend_den   <= den_in;
            pend_valid <= 1'b1;
        end else if (frame_edge) begin
            pend_valid <= 1'b0;
        end
    end

    // Active buffer and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_value  <= '0;
            act_dp     <= '0;
            act_den    <= '0;
            nibble     <= '0;
            nib_en     <= 1'b0;
            an         <= AN_OFF;
            dp         <= DP_OFF;
            frame_tick <= 1'b0;
        end else begin
            act_value  <= act_value_next;
            act_dp     <= act_dp_next;
            act_den    <= act_den_next;
            nibble     <= nibble_next;
            nib_en     <= nib_en_next;
            an         <= an_next;
            dp         <= dp_next;
            frame_tick <= frame_edge;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with a cycle-count based reference model.
module tb_seg_scan_ctrl;

    localparam int DT = 8;
    localparam int BT = 2;
    localparam int FR = 4 * DT;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic [3:0]  den_in;
    logic [3:0]  nibble;
    logic        nib_en;
    logic [3:0]  an;
    logic        dp;
    logic        pend_valid;
    logic        frame_tick;

    seg_scan_ctrl #(
        .DIGIT_TICKS (DT),
        .BLANK_TICKS (BT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .den_in     (den_in),
        .nibble     (nibble),
        .nib_en     (nib_en),
        .an         (an),
        .dp         (dp),
        .pend_valid (pend_valid),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: time since reset release plus what the display shows / holds.
    int          t;
    logic [15:0] m_val,  m_pval;
    logic [3:0]  m_dp,   m_pdp;
    logic [3:0]  m_den,  m_pden;
    bit          m_pv;
    int          checks;
    int          failures;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        t      = 0;
        m_val  = '0; m_dp  = '0; m_den  = '0;
        m_pval = '0; m_pdp = '0; m_pden = '0;
        m_pv   = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_an",     16'(an),         16'hF);
        chk("rst_nib_en", 16'(nib_en),     16'h0);
        chk("rst_nibble", 16'(nibble),     16'h0);
        chk("rst_dp",     16'(dp),         16'h1);
        chk("rst_pend",   16'(pend_valid), 16'h0);
        chk("rst_ftick",  16'(frame_tick), 16'h0);
    endtask

    // One cycle: check the current cycle, drive inputs, advance the model.
    task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] p, input logic [3:0] e);
        int         slot_pos;
        int         d;
        bit         driven;
        bit         fe;
        logic [3:0] e_an;
        logic [3:0] sel;
        slot_pos = t % DT;
        d        = (t / DT) % 4;
        driven   = (slot_pos >= BT) && m_den[d];
        sel      = 4'b0001 << d;
        e_an     = driven ? ~sel : 4'hF;
        chk("nibble",     16'(nibble),     16'((m_val >> (4 * d)) & 16'hF));
        chk("nib_en",     16'(nib_en),     16'(driven));
        chk("an",         16'(an),         16'(e_an));
        chk("dp",         16'(dp),         driven ? 16'(!m_dp[d]) : 16'h1);
        chk("pend_valid", 16'(pend_valid), 16'(m_pv));
        chk("frame_tick", 16'(frame_tick), 16'((t > 0) && (t % FR == 0)));

        load     = ld;
        value_in = v;
        dp_in    = p;
        den_in   = e;
        fe       = (t % FR == FR - 1);
        if (ld)
            $display("load t=%0d value=%h dp=%b den=%b on_frame_edge=%0d", t, v, p, e, fe);
        if (fe) begin
            if (ld) begin
                m_val = v; m_dp = p; m_den = e;
            end else if (m_pv) begin
                m_val = m_pval; m_dp = m_pdp; m_den = m_pden;
            end
            m_pv = 1'b0;
        end else if (ld) begin
            m_pval = v; m_pdp = p; m_pden = e;
            m_pv   = 1'b1;
        end
        t++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic run_to(input int phase);
        while (t % FR != phase) idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        value_in = '0;
        dp_in    = '0;
        den_in   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst_n = 1'b1;

        // Blank display through the first frame; frame_tick at t=32 only.
        repeat (34) idle();

        // Single mid-frame load.
        run_to(12);
        step(1'b1, 16'h4A7C, 4'b0100, 4'hF);
        run_to(0);
        repeat (FR) idle();

        // Two loads in one frame: last wins.
        run_to(5);
        step(1'b1, 16'h1111, 4'h0, 4'hF);
        run_to(20);
        step(1'b1, 16'h2222, 4'h0, 4'hF);
        run_to(0);
        repeat (FR) idle();

        // Load on the frame-edge cycle while something is pending.
        run_to(10);
        step(1'b1, 16'h5555, 4'h0, 4'hF);
        run_to(FR - 1);
        step(1'b1, 16'h9999, 4'h0, 4'hF);
        repeat (FR + 1) idle();

        // Partial digit enables.
        run_to(3);
        step(1'b1, 16'($urandom), 4'($urandom), 4'b0101);
        run_to(0);
        repeat (FR) idle();

        // Random traffic, with extra loads aimed at frame edges.
        repeat (800) begin
            bit ld;
            ld = ($urandom_range(0, 9) == 0) ||
                 ((t % FR == FR - 1) && ($urandom_range(0, 1) == 1));
            step(ld, 16'($urandom), 4'($urandom), 4'($urandom));
        end

        // Reset mid-frame at digit 2, cnt 5 with data pending.
        run_to(5);
        step(1'b1, 16'hBEEF, 4'hF, 4'hF);
        run_to(2 * DT + 5);
        rst_n = 1'b0;
        load  = 1'b0;
        #1;
        chk_reset_outputs();
        @(posedge clk);
        #1;
        chk_reset_outputs();
        rst_n = 1'b1;
        model_reset();
        repeat (FR + 8) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
